// File: rtl/water_mark_pkg.sv
// Shared types and the per-lane combine function for the watermark embedder.
package water_mark_pkg;

    // Widest lane the combine function supports; narrower lanes are zero-extended.
    localparam int unsigned WM_PIX_MAX = 32;
    localparam int unsigned WM_PIX_EXT = WM_PIX_MAX + 1;

    typedef logic [WM_PIX_MAX-1:0] wm_pix_t;

    typedef enum logic [1:0] {
        MODE_BYPASS = 2'd0,
        MODE_LSB    = 2'd1,
        MODE_XOR    = 2'd2,
        MODE_SATADD = 2'd3
    } wm_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_EMBED = 2'd2,
        ST_DRAIN = 2'd3
    } wm_state_e;

    // Combine one image lane with one watermark lane; pw is the lane width and
    // lsb_bits the number of low bits replaced in LSB mode. Inputs must be zero above pw.
    function automatic wm_pix_t wm_lane_combine(
        input wm_mode_e     mode,
        input logic [2:0]   shift,
        input wm_pix_t      i,
        input wm_pix_t      w,
        input int unsigned  pw,
        input int unsigned  lsb_bits
    );
        logic [WM_PIX_EXT-1:0] full;
        logic [WM_PIX_EXT-1:0] lmask;
        logic [WM_PIX_EXT-1:0] s;
        logic [WM_PIX_EXT-1:0] o;
        full  = WM_PIX_EXT'((64'd1 << pw) - 64'd1);
        lmask = WM_PIX_EXT'((64'd1 << lsb_bits) - 64'd1);
        s     = {1'b0, i} + ({1'b0, w} >> shift);
        case (mode)
            MODE_BYPASS: o = {1'b0, i};
            MODE_LSB:    o = ({1'b0, i} & ~lmask) | ({1'b0, w} & lmask);
            MODE_XOR:    o = {1'b0, i ^ w};
            default:     o = ((s & ~full) != '0) ? full : s;
        endcase
        return wm_pix_t'(o & full);
    endfunction

endpackage

// File: rtl/water_mark_buf.sv
// Simple dual-port watermark tile buffer with registered, enabled read port.
module water_mark_buf #(
    parameter int unsigned C_DEPTH = 256,
    parameter int unsigned C_WIDTH = 512,
    parameter int unsigned C_AW    = 8
) (
    input  logic               i_clk,
    input  logic               i_wr_en,
    input  logic [C_AW-1:0]    i_wr_addr,
    input  logic [C_WIDTH-1:0] i_wr_data,
    input  logic               i_rd_en,
    input  logic [C_AW-1:0]    i_rd_addr,
    output logic [C_WIDTH-1:0] o_rd_data
);

    logic [C_WIDTH-1:0] r_mem [C_DEPTH];
    logic [C_WIDTH-1:0] r_rd_data;

    // Write port and registered read port; no reset so it maps onto block RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

// File: rtl/water_mark_embed_mc.sv
// Streaming watermark embedder: loads a tile, then combines it cyclically with image beats.
module water_mark_embed_mc
    import water_mark_pkg::*;
#(
    parameter int unsigned C_DATA_WIDTH  = 512,
    parameter int unsigned C_PIXEL_WIDTH = 8,
    parameter int unsigned C_WM_DEPTH    = 256,
    parameter int unsigned C_LSB_BITS    = 1,
    parameter int unsigned C_CNT_WIDTH   = 32
) (
    input  logic                    kernel_clk,
    input  logic                    kernel_rst,
    input  logic                    ctrl_start,
    input  logic [1:0]              ctrl_mode,
    input  logic [2:0]              ctrl_shift,
    output logic                    ctrl_done,
    input  logic [C_DATA_WIDTH-1:0] s_axis_wm_tdata,
    input  logic                    s_axis_wm_tvalid,
    input  logic                    s_axis_wm_tlast,
    output logic                    s_axis_wm_tready,
    input  logic [C_DATA_WIDTH-1:0] s_axis_im_tdata,
    input  logic                    s_axis_im_tvalid,
    input  logic                    s_axis_im_tlast,
    output logic                    s_axis_im_tready,
    output logic [C_DATA_WIDTH-1:0] m_axis_im_tdata,
    output logic                    m_axis_im_tvalid,
    output logic                    m_axis_im_tlast,
    input  logic                    m_axis_im_tready,
    output logic [C_CNT_WIDTH-1:0]  stat_beat_count,
    output logic                    stat_wm_overflow
);

    localparam int unsigned P     = C_PIXEL_WIDTH;
    localparam int unsigned L     = C_DATA_WIDTH / C_PIXEL_WIDTH;
    localparam int unsigned AW    = (C_WM_DEPTH > 1) ? $clog2(C_WM_DEPTH) : 1;
    localparam int unsigned LEN_W = AW + 1;

    wm_state_e          r_state;
    wm_mode_e           r_mode;
    logic [2:0]         r_shift;
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [LEN_W-1:0]   r_wm_len;

    logic                    r_a_valid;
    logic                    r_a_last;
    logic [C_DATA_WIDTH-1:0] r_a_data;

    logic                    w_adv;
    logic                    w_wm_hs;
    logic                    w_im_hs;
    logic                    w_m_hs;
    logic                    w_buf_full;
    logic                    w_wr_en;
    logic [C_DATA_WIDTH-1:0] w_rd_data;
    logic [C_DATA_WIDTH-1:0] w_comb;

    // Handshakes and pipeline advance; both stages move together whenever the output can take a beat.
    assign w_adv            = ~m_axis_im_tvalid | m_axis_im_tready;
    assign s_axis_wm_tready = (r_state == ST_LOAD);
    assign s_axis_im_tready = (r_state == ST_EMBED) & w_adv;
    assign w_wm_hs          = s_axis_wm_tvalid & s_axis_wm_tready;
    assign w_im_hs          = s_axis_im_tvalid & s_axis_im_tready;
    assign w_m_hs           = m_axis_im_tvalid & m_axis_im_tready;
    assign w_buf_full       = (r_wm_len == LEN_W'(C_WM_DEPTH));
    assign w_wr_en          = w_wm_hs & ~w_buf_full;

    water_mark_buf #(
        .C_DEPTH (C_WM_DEPTH),
        .C_WIDTH (C_DATA_WIDTH),
        .C_AW    (AW)
    ) u_buf (
        .i_clk     (kernel_clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (s_axis_wm_tdata),
        .i_rd_en   (w_adv),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // Control FSM: run setup, tile load, tiled read pointer, completion and statistics.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            r_state          <= ST_IDLE;
            r_mode           <= MODE_BYPASS;
            r_shift          <= 3'd0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_wm_len         <= '0;
            ctrl_done        <= 1'b0;
            stat_beat_count  <= '0;
            stat_wm_overflow <= 1'b0;
        end else begin
            ctrl_done <= 1'b0;
            if (w_m_hs) begin
                stat_beat_count <= stat_beat_count + C_CNT_WIDTH'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        r_state          <= ST_LOAD;
                        r_mode           <= wm_mode_e'(ctrl_mode);
                        r_shift          <= ctrl_shift;
                        r_wr_ptr         <= '0;
                        r_rd_ptr         <= '0;
                        r_wm_len         <= '0;
                        stat_beat_count  <= '0;
                        stat_wm_overflow <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (w_wm_hs) begin
                        if (w_buf_full) begin
                            stat_wm_overflow <= 1'b1;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + AW'(1);
                            r_wm_len <= r_wm_len + LEN_W'(1);
                        end
                        if (s_axis_wm_tlast) begin
                            r_state <= ST_EMBED;
                        end
                    end
                end
                ST_EMBED: begin
                    if (w_im_hs) begin
                        if (LEN_W'(r_rd_ptr) + LEN_W'(1) == r_wm_len) begin
                            r_rd_ptr <= '0;
                        end else begin
                            r_rd_ptr <= r_rd_ptr + AW'(1);
                        end
                        if (s_axis_im_tlast) begin
                            r_state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_m_hs && m_axis_im_tlast) begin
                        ctrl_done <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Per-lane combine of the stage-A image beat with the buffer word read alongside it.
    for (genvar g = 0; g < L; g++) begin : g_lane
        logic [P-1:0] w_lane;
        assign w_lane = P'(wm_lane_combine(r_mode, r_shift,
                                           wm_pix_t'(r_a_data[g*P +: P]),
                                           wm_pix_t'(w_rd_data[g*P +: P]),
                                           P, C_LSB_BITS));
        assign w_comb[g*P +: P] = w_lane;
    end

    // Two-stage datapath: stage A captures the image beat, stage B drives m_axis.
    always_ff @(posedge kernel_clk) begin
        if (kernel_rst) begin
            r_a_valid        <= 1'b0;
            r_a_last         <= 1'b0;
            r_a_data         <= '0;
            m_axis_im_tvalid <= 1'b0;
            m_axis_im_tlast  <= 1'b0;
            m_axis_im_tdata  <= '0;
        end else if (w_adv) begin
            r_a_valid <= w_im_hs;
            if (w_im_hs) begin
                r_a_data <= s_axis_im_tdata;
                r_a_last <= s_axis_im_tlast;
            end
            m_axis_im_tvalid <= r_a_valid;
            m_axis_im_tlast  <= r_a_valid & r_a_last;
            if (r_a_valid) begin
                m_axis_im_tdata <= w_comb;
            end
        end
    end

endmodule
